// File: rtl/axi3_pkg.sv
// Shared AXI3 read-channel types, field widths and burst address helpers.
// No latency or backpressure of its own.
package axi3_pkg;

    localparam int AXI3_ADDR_W = 32;
    localparam int AXI3_LEN_W  = 4;
    localparam int AXI3_SIZE_W = 3;

    typedef enum logic [1:0] {
        AXI3_FIXED = 2'b00,
        AXI3_INCR  = 2'b01,
        AXI3_WRAP  = 2'b10
    } axi3_burst_t;

    typedef enum logic [1:0] {
        AXI3_OKAY   = 2'b00,
        AXI3_EXOKAY = 2'b01,
        AXI3_SLVERR = 2'b10,
        AXI3_DECERR = 2'b11
    } axi3_resp_t;

    // Byte address of the beat following addr; arithmetic wraps modulo 2^32.
    function automatic logic [AXI3_ADDR_W-1:0] axi3_next_addr(
        input logic [AXI3_ADDR_W-1:0] addr,
        input logic [AXI3_LEN_W-1:0]  len,
        input logic [AXI3_SIZE_W-1:0] size,
        input axi3_burst_t            burst
    );
        logic [AXI3_ADDR_W-1:0] step;
        logic [AXI3_ADDR_W-1:0] mask;
        step = 32'd1 << size;
        mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            AXI3_FIXED: axi3_next_addr = addr;
            AXI3_WRAP:  axi3_next_addr = (addr & ~mask) | ((addr + step) & mask);
            default:    axi3_next_addr = addr + step;
        endcase
    endfunction

    function automatic logic axi3_ar_slverr(
        input logic [AXI3_SIZE_W-1:0] size,
        input logic [1:0]             burst,
        input logic [AXI3_LEN_W-1:0]  len,
        input logic [AXI3_SIZE_W-1:0] max_size
    );
        logic wrap_len_ok;
        wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        axi3_ar_slverr = (size > max_size) || (burst == 2'b11) ||
                         ((burst == AXI3_WRAP) && !wrap_len_ok);
    endfunction

endpackage

// File: rtl/axi3_rd_skid.sv
// 2-entry first-word-fall-through buffer with same-cycle bypass when empty.
// Latency 0 (push visible at output immediately); holds up to 2 entries while pop_rdy is low.
module axi3_rd_skid #(
    parameter int W = 35
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         empty;
    logic         wr_en;
    logic         rd_en;

    assign empty   = (count == 2'd0);
    assign out_vld = !empty || push_vld;
    assign out_dat = empty ? push_dat : mem[rd_ptr];
    // An arriving entry consumed in the same cycle never touches storage.
    assign wr_en   = push_vld && !(empty && pop_rdy);
    assign rd_en   = pop_rdy && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            count <= count + {1'b0, wr_en} - {1'b0, rd_en};
            if (wr_en) wr_ptr <= !wr_ptr;
            if (rd_en) rd_ptr <= !rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/axi3_rd_ram_slave.sv
// AXI3 read responder over a synchronous-read word RAM, one burst outstanding.
// AR accept at T -> mem_en T+1 -> rvalid T+2; rready stalls absorbed by a 2-entry skid, no bubbles.
module axi3_rd_ram_slave
    import axi3_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int MEM_ADDR_WIDTH = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ID_WIDTH-1:0]       arid,
    input  logic [31:0]               araddr,
    input  logic [3:0]                arlen,
    input  logic [2:0]                arsize,
    input  logic [1:0]                arburst,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [ID_WIDTH-1:0]       rid,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rlast,
    output logic                      rvalid,
    input  logic                      rready,
    output logic                      mem_en,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_rddata
);

    localparam int BL = $clog2(DATA_WIDTH / 8);
    localparam int SW = DATA_WIDTH + 3;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t                state, state_nxt;
    logic [ID_WIDTH-1:0]   id_q;
    logic [31:0]           addr_q;
    logic [3:0]            len_q;
    logic [2:0]            size_q;
    axi3_burst_t           burst_q;
    logic                  slverr_q;
    logic [4:0]            issued_q;
    logic                  inflight_q;
    axi3_resp_t            ret_resp_q;
    logic                  ret_last_q;

    logic                  ar_hs;
    logic                  last_hs;
    logic                  issue;
    logic                  decerr;
    axi3_resp_t            beat_resp;
    logic [DATA_WIDTH-1:0] ret_data;
    logic [SW-1:0]         push_dat;
    logic [SW-1:0]         sk_dat;
    logic [1:0]            sk_cnt;

    always_comb begin
        state_nxt = state;
        arready   = 1'b0;
        case (state)
            S_IDLE: begin
                arready = !rst;
                if (arvalid && !rst) state_nxt = S_BURST;
            end
            S_BURST: if (last_hs) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign ar_hs   = arvalid && arready;
    assign last_hs = rvalid && rready && rlast;

    // Issue only while the skid can still take every beat already in flight.
    assign issue     = (state == S_BURST) && (issued_q <= {1'b0, len_q}) &&
                       (({1'b0, sk_cnt} + {2'b00, inflight_q}) < 3'd2);
    assign decerr    = |addr_q[31:MEM_ADDR_WIDTH+BL];
    assign beat_resp = slverr_q ? AXI3_SLVERR : (decerr ? AXI3_DECERR : AXI3_OKAY);
    assign mem_en    = issue && (beat_resp == AXI3_OKAY);
    assign mem_addr  = addr_q[MEM_ADDR_WIDTH+BL-1:BL];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= AXI3_FIXED;
            slverr_q   <= 1'b0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            ret_resp_q <= AXI3_OKAY;
            ret_last_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            inflight_q <= issue;
            if (ar_hs) begin
                id_q     <= arid;
                addr_q   <= araddr;
                len_q    <= arlen;
                size_q   <= arsize;
                burst_q  <= axi3_burst_t'(arburst);
                slverr_q <= axi3_ar_slverr(arsize, arburst, arlen, 3'(BL));
                issued_q <= '0;
            end
            if (issue) begin
                addr_q     <= axi3_next_addr(addr_q, len_q, size_q, burst_q);
                issued_q   <= issued_q + 5'd1;
                ret_resp_q <= beat_resp;
                ret_last_q <= (issued_q[3:0] == len_q);
            end
        end
    end

    assign ret_data = (inflight_q && (ret_resp_q == AXI3_OKAY)) ? mem_rddata : '0;
    assign push_dat = inflight_q ? {ret_data, ret_resp_q, ret_last_q} : '0;

    axi3_rd_skid #(.W(SW)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push_vld (inflight_q),
        .push_dat (push_dat),
        .pop_rdy  (rready),
        .out_vld  (rvalid),
        .out_dat  (sk_dat),
        .count    (sk_cnt)
    );

    assign {rdata, rresp, rlast} = sk_dat;
    assign rid = id_q;

endmodule

// File: tb/tb_axi3_rd_ram_slave.sv
// Directed bench with beat/address scoreboard for axi3_rd_ram_slave.
module tb_axi3_rd_ram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        mem_en;
    logic [13:0] mem_addr;
    logic [31:0] mem_rddata = '0;

    axi3_rd_ram_slave #(.DATA_WIDTH(32), .ID_WIDTH(4), .MEM_ADDR_WIDTH(14)) dut (
        .clk(clk), .rst(rst), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rddata(mem_rddata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [13:0] maddr_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          n_hs = 0;
    int          n_hs_ok = 0;
    int          n_issue = 0;
    int          hs_cyc [512];
    logic        stall_prev = 1'b0;
    logic [38:0] held;
    beat_t       e;

    function automatic logic [31:0] ram_word(input logic [13:0] w);
        return {2'b10, w, 2'b01, w};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) mem_rddata <= ram_word(mem_addr);
    end

    // Monitor: RAM requests and R beats against the scoreboard queues.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            maddr_q.delete();
            n_issue    = n_hs_ok;
            stall_prev = 1'b0;
        end else begin
            if (mem_en) begin
                chk("mem_outstanding", ((n_issue - n_hs_ok) < 2), 1);
                n_issue++;
                if (maddr_q.size() == 0) chk("mem_en_unexpected", mem_en, 0);
                else chk("mem_addr", mem_addr, maddr_q.pop_front());
            end
            if (stall_prev) begin
                chk("stall_rvalid", rvalid, 1);
                chk("stall_hold", {rid, rdata, rresp, rlast}, held);
            end
            if (rvalid && rready) begin
                hs_cyc[n_hs] = cyc;
                n_hs++;
                if (rresp == 2'b00) n_hs_ok++;
                if (exp_q.size() == 0) chk("r_unexpected", rvalid, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("rid", rid, e.id);
                    chk("rdata", rdata, e.data);
                    chk("rresp", rresp, e.resp);
                    chk("rlast", rlast, e.last);
                end
            end
            stall_prev = rvalid && !rready;
            held       = {rid, rdata, rresp, rlast};
        end
    end

    task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] bt, output int t);
        bit          serr;
        logic [31:0] cur, step, bound, lower;
        beat_t       b;
        serr  = (size > 3'd2) || (bt == 2'b11) ||
                ((bt == 2'b10) && !(len == 1 || len == 3 || len == 7 || len == 15));
        cur   = a;
        step  = 32'd1 << size;
        bound = (32'(len) + 32'd1) * step;
        for (int i = 0; i <= int'(len); i++) begin
            b.id   = id;
            b.last = (i == int'(len));
            if (serr) begin
                b.resp = 2'b10; b.data = '0;
            end else if (cur >= 32'h0001_0000) begin
                b.resp = 2'b11; b.data = '0;
            end else begin
                b.resp = 2'b00; b.data = ram_word(cur[15:2]);
                maddr_q.push_back(cur[15:2]);
            end
            exp_q.push_back(b);
            if (bt == 2'b01) cur = cur + step;
            else if (bt == 2'b10) begin
                lower = cur - (cur % bound);
                cur   = lower + ((cur - lower + step) % bound);
            end
        end
        arid = id; araddr = a; arlen = len; arsize = size; arburst = bt; arvalid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (arready) break;
        end
        t = cyc;
        chk("ar_accept", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_drain(input int pat, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            rready = (pat == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 3));
            if (exp_q.size() == 0) break;
        end
        rready = 1'b1;
        chk("drain_beats", exp_q.size(), 0);
        chk("drain_maddr", maddr_q.size(), 0);
    endtask

    initial begin
        int t, base;
        rst = 1'b1; arvalid = 1'b0; rready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", arready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_rid", rid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_mem_en", mem_en, 0);
        @(posedge clk); #1;
        rst = 1'b0; rready = 1'b1;
        @(negedge clk);
        chk("arready_after_rst", arready, 1);
        @(posedge clk); #1;

        base = n_hs;
        send_ar(4'd1, 32'h100, 4'd3, 3'd2, 2'b01, t);
        wait_drain(0, 100);
        chk("lat_first_beat", hs_cyc[base], t + 2);
        chk("lat_last_beat", hs_cyc[base+3], t + 5);

        send_ar(4'd2, 32'h38, 4'd7, 3'd2, 2'b10, t);
        wait_drain(0, 100);

        base = n_hs;
        send_ar(4'd3, 32'h200, 4'd15, 3'd2, 2'b01, t);
        wait_drain(1, 300);
        chk("incr16_beats", n_hs - base, 16);

        send_ar(4'd4, 32'h0, 4'd1, 3'd3, 2'b01, t);
        wait_drain(0, 100);

        send_ar(4'd6, 32'hFFFC, 4'd1, 3'd2, 2'b01, t);
        wait_drain(0, 100);

        send_ar(4'd7, 32'h44, 4'd2, 3'd2, 2'b00, t);
        wait_drain(1, 100);
        send_ar(4'd8, 32'h0, 4'd0, 3'd2, 2'b11, t);
        wait_drain(0, 100);
        send_ar(4'd9, 32'h80, 4'd2, 3'd2, 2'b10, t);
        wait_drain(0, 100);

        base = n_hs;
        send_ar(4'd10, 32'h300, 4'd3, 3'd2, 2'b01, t);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (n_hs >= base + 2) break;
        end
        chk("mid_rst_beats_before", n_hs - base, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_mem_en", mem_en, 0);
        chk("mid_rst_arready", arready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_arready", arready, 1);
        chk("post_rst_rvalid", rvalid, 0);
        @(posedge clk); #1;
        base = n_hs;
        send_ar(4'd5, 32'h10, 4'd0, 3'd2, 2'b01, t);
        wait_drain(0, 100);
        chk("post_rst_beats", n_hs - base, 1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
